ireg_dump_reader: RTL and testbench
===================================

// Module: ireg_dump_reader
// PURPOSE
//  Debug reader for the integer register file. On a start pulse it walks read
//  addresses 0..NREG-1 on one combinational read port (addr out, data in same cycle).
//  It streams each word out over a valid/ready interface, one registered output stage.
//  Sits beside the CPU core; muxes onto read port r1 when dbg_busy=1.
// PARAMETERS
//  ADDR_W  6   register address width
//  DATA_W  32  register data width
//  NREG    64  number of registers dumped, 1..2**ADDR_W
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       1-cycle pulse: begin dump (ignored unless IDLE)
//  abort      in   1       synchronous abort: drop everything, return to IDLE
//  rd_addr    out  ADDR_W  read address to register file port
//  rd_data    in   DATA_W  combinational read data for rd_addr
//  dbg_busy   out  1       1 in RUN/DRAIN; core must yield read port
//  out_valid  out  1       output word valid
//  out_ready  in   1       sink accepts word when out_valid&out_ready
//  out_data   out  DATA_W  register contents
//  out_addr   out  ADDR_W  address the word came from
//  out_last   out  1       1 on word from address NREG-1
//  done       out  1       1-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset: state=IDLE, rd_addr=0, dbg_busy=0, out_valid=0, out_data=0, out_addr=0,
//   out_last=0, done=0. Reset mid-dump discards all progress; no done pulse.
//  FSM states: IDLE, RUN, DRAIN.
//   IDLE -start-> RUN (rd_addr=0). Start in RUN/DRAIN ignored.
//   RUN: capture when output stage free: out_valid==0 or out_ready==1.
//    On capture: out_data<=rd_data, out_addr<=rd_addr, out_valid<=1,
//    out_last<=(rd_addr==NREG-1). If rd_addr==NREG-1 -> DRAIN, else rd_addr+1.
//   DRAIN: on out_valid&out_ready&out_last -> IDLE, out_valid<=0, done<=1 next cycle.
//  Latency: start at edge N -> first out_valid at edge N+2 (one cycle to RUN,
//   one to capture). No stalls: one word per cycle; NREG words take NREG cycles.
//  Back-pressure: while out_valid&!out_ready, out_data/out_addr/out_last stable;
//   rd_addr holds; no capture.
//  rd_addr never exceeds NREG-1; it does not wrap. Returns to 0 in IDLE.
//  Coherency: each word reflects register contents at its capture cycle.
//   A core write to the same address at that edge is not seen.
//  abort (any state) at edge: next cycle IDLE, out_valid=0, rd_addr=0; no done.
//   abort has priority over start in the same cycle.
//  NREG=1: single word with out_last=1; FSM RUN->DRAIN on first capture.
// CONFIGURATION
//  IREG_DUMP_CSUM_EN defined: adds output csum[DATA_W-1:0], XOR of every accepted
//   out_data word. Cleared to 0 on start accepted and on reset. Holds its final value
//   from the done pulse until the next start.
//  IREG_DUMP_CSUM_EN undefined: no csum port, no XOR logic; behaviour otherwise identical.
// TESTING
//  1 Preload reg[i]=i*3+1, NREG=64, out_ready=1, pulse start.
//    -> 64 words, addrs 0..63 back-to-back, out_last only on addr 63, done 1 cycle later.
//  2 Same as 1, out_ready low for 3 cycles at addr 10.
//    -> addr 10 word held stable 3 cycles; rd_addr stays 11; no duplicates or gaps.
//  3 Start pulsed again at addr 20 during dump.
//    -> ignored; dump completes normally with a single done.
//  4 abort at addr 30 (with start same cycle).
//    -> out_valid=0 next cycle, rd_addr=0, no done; later start dumps from addr 0.
//  5 rst_n low mid-dump at addr 40.
//    -> all outputs at reset values immediately; dbg_busy=0.
//  6 IREG_DUMP_CSUM_EN, regs 0..63 = 0xA5A5_0000|i.
//    -> csum=0x0000_0000 at done (64 even count cancels high half; XOR of 0..63 = 0).

Source files
------------

// File: rtl/ireg_dump_reader.sv
// ---------------------------------------------------------------------------
// ireg_dump_reader
//
// Debug reader for the integer register file. A start pulse walks read
// addresses 0..NREG-1 on one combinational read port and streams every word
// out over a valid/ready interface through a single registered output stage.
// While dbg_busy is high the core must yield its read port r1 to this block.
//
// Optional feature: define IREG_DUMP_CSUM_EN to add the csum output, the XOR
// of every accepted out_data word (cleared on reset and when a start is
// accepted, and held after done until the next start).
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       one-cycle pulse, begins a dump (only honoured in IDLE)
//   abort      in   1       synchronous abort, returns to IDLE, outranks start
//   rd_addr    out  ADDR_W  register file read address
//   rd_data    in   DATA_W  combinational read data for rd_addr
//   dbg_busy   out  1       high in RUN and DRAIN
//   out_valid  out  1       output word valid
//   out_ready  in   1       sink accepts the word when out_valid & out_ready
//   out_data   out  DATA_W  register contents
//   out_addr   out  ADDR_W  address the word was read from
//   out_last   out  1       marks the word from address NREG-1
//   done       out  1       one-cycle pulse after the last word is accepted
//   csum       out  DATA_W  XOR of accepted words (IREG_DUMP_CSUM_EN only)
// ---------------------------------------------------------------------------
module ireg_dump_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int NREG   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dbg_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done
`ifdef IREG_DUMP_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

  state_t state;

  // The output stage can take a new word when it is empty or its current
  // word leaves at this edge.
  logic out_free;
  logic out_fire;
  logic at_last;

  assign out_free = !out_valid || out_ready;
  assign out_fire = out_valid && out_ready;
  assign at_last  = (rd_addr == LAST_ADDR);

  // NOTE: all state and registered outputs update with non-blocking
  // assignments so every branch sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      dbg_busy  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: done defaults low every cycle so it can only ever be a
      // single-cycle pulse, and no path leaves it unassigned.
      done <= 1'b0;

      if (abort) begin
        state     <= IDLE;
        rd_addr   <= '0;
        dbg_busy  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              rd_addr  <= '0;
              dbg_busy <= 1'b1;
            end
          end

          RUN: begin
            // Under back-pressure nothing moves: word, address and read
            // pointer all hold until the sink takes the word.
            if (out_free) begin
              out_data  <= rd_data;
              out_addr  <= rd_addr;
              out_last  <= at_last;
              out_valid <= 1'b1;
              if (at_last) begin
                state <= DRAIN;
              end else begin
                rd_addr <= rd_addr + ADDR_W'(1);
              end
            end
          end

          DRAIN: begin
            // Only the last word can be in the stage here.
            if (out_fire && out_last) begin
              state     <= IDLE;
              rd_addr   <= '0;
              dbg_busy  <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            rd_addr  <= '0;
            dbg_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef IREG_DUMP_CSUM_EN
  // Running XOR of accepted words; an aborted dump leaves it partial, the
  // next accepted start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        csum <= '0;
      end else if (out_fire) begin
        csum <= csum ^ out_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ireg_dump_reader.sv
// ---------------------------------------------------------------------------
// tb_ireg_dump_reader
//
// Drives ireg_dump_reader against a behavioural register file. The reference
// is the dump contract itself: accepted words must appear in address order
// 0..NREG-1, each carrying mem[addr], with out_last only on the final one and
// exactly one done pulse the cycle after the final acceptance. Covers reset,
// back-to-back dumps, a forced stall, a re-start during a dump, random sink
// throttling, abort (with start), reset mid-dump and, when IREG_DUMP_CSUM_EN
// is defined, the checksum.
// ---------------------------------------------------------------------------
module tb_ireg_dump_reader;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int NREG   = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              dbg_busy;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              done;
`ifdef IREG_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  logic [DATA_W-1:0] mem [NREG];

  int n_vec = 0;
  int n_err = 0;

  int cyc          = 0;
  int exp_idx      = 0;
  int n_done       = 0;
  int first_acc_cyc = 0;
  int last_acc_cyc = 0;
  int done_cyc     = 0;

  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic [ADDR_W-1:0] prev_addr;
  logic [ADDR_W-1:0] prev_rd;
  logic              prev_last;

  always #5 clk = ~clk;

  // Combinational register-file read port.
  assign rd_data = mem[rd_addr];

  ireg_dump_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .NREG  (NREG)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .dbg_busy (dbg_busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last),
    .done     (done)
`ifdef IREG_DUMP_CSUM_EN
    ,
    .csum     (csum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe at the falling edge, then return 1 time unit
  // after the rising edge so the caller can drive the next inputs.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (stall_prev) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
      check("hold_addr", 32'(out_addr), 32'(prev_addr));
      check("hold_last", 32'(out_last), 32'(prev_last));
      check("hold_rd_addr", 32'(rd_addr), 32'(prev_rd));
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      check("word_addr", 32'(out_addr), exp_idx);
      check("word_data", out_data, mem[exp_idx % NREG]);
      check("word_last", 32'(out_last), 32'(exp_idx == NREG - 1));
      if (exp_idx == 0) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
      exp_idx++;
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    prev_addr  = out_addr;
    prev_last  = out_last;
    prev_rd    = rd_addr;
    @(posedge clk);
    #1;
  endtask

  // Pulse start and check the two-edge latency to the first valid word.
  task automatic start_dump(input string tag);
    exp_idx    = 0;
    stall_prev = 1'b0;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_lat_busy"}, 32'(dbg_busy), 32'd1);
    check({tag, "_lat_novalid"}, 32'(out_valid), 32'd0);
`ifdef IREG_DUMP_CSUM_EN
    check({tag, "_csum_clear"}, csum, 32'd0);
`endif
    @(posedge clk);
    #1;
    check({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat_addr0"}, 32'(out_addr), 32'd0);
  endtask

  // Complete dump with optional random throttling, a 3-cycle stall at
  // stall_addr and a spurious start at restart_addr (negative = none).
  task automatic run_dump(input string tag, input bit rand_ready,
                          input int stall_addr, input int restart_addr);
    int d0;
    int i;
    bit stalled;
    bit restarted;
    logic [DATA_W-1:0] exp_csum;
    d0        = n_done;
    i         = 0;
    stalled   = 1'b0;
    restarted = 1'b0;
    start_dump(tag);
    while (n_done == d0 && i < 1000) begin
      if (!stalled && out_valid && 32'(out_addr) == stall_addr) begin
        check({tag, "_stall_rd_addr"}, 32'(rd_addr), stall_addr + 1);
        out_ready = 1'b0;
        repeat (3) step();
        i += 3;
        stalled   = 1'b1;
        out_ready = 1'b1;
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!restarted && out_valid && 32'(out_addr) == restart_addr) begin
        start     = 1'b1;
        restarted = 1'b1;
      end
      step();
      start = 1'b0;
      i++;
    end
    out_ready = 1'b1;
    check({tag, "_done_seen"}, n_done, d0 + 1);
    check({tag, "_word_count"}, exp_idx, NREG);
    check({tag, "_done_timing"}, done_cyc, last_acc_cyc + 1);
    if (!rand_ready) begin
      check({tag, "_b2b_span"}, last_acc_cyc - first_acc_cyc,
            NREG - 1 + (stall_addr >= 0 ? 3 : 0));
    end
    repeat (3) step();
    check({tag, "_single_done"}, n_done, d0 + 1);
    check({tag, "_idle_busy"}, 32'(dbg_busy), 32'd0);
    check({tag, "_idle_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
`ifdef IREG_DUMP_CSUM_EN
    exp_csum = '0;
    for (int k = 0; k < NREG; k++) exp_csum ^= mem[k];
    check({tag, "_csum"}, csum, exp_csum);
`else
    exp_csum = '0;
`endif
  endtask

  // Step until the word at addr is presented; returns 0 if never seen.
  task automatic run_to_addr(input int addr, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (out_valid && 32'(out_addr) == addr) found = 1'b1;
      else step();
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < NREG; k++) mem[k] = $urandom;
  endtask

  initial begin
    bit found;
    int d0;

    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NREG; k++) mem[k] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_busy", 32'(dbg_busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: fixed pattern, free-running sink
    for (int k = 0; k < NREG; k++) mem[k] = 32'(k * 3 + 1);
    run_dump("t1", 1'b0, -1, -1);

    // 2: random contents, 3-cycle stall at address 10
    fill_random();
    run_dump("t2", 1'b0, 10, -1);

    // 3: spurious start during the dump at address 20
    fill_random();
    run_dump("t3", 1'b0, -1, 20);

    // Random sink throttling
    fill_random();
    run_dump("trand", 1'b1, -1, -1);

    // 4: abort together with start at address 30
    fill_random();
    start_dump("t4");
    run_to_addr(30, found);
    check("t4_reach30", 32'(found), 32'd1);
    d0    = n_done;
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("t4_abort_valid", 32'(out_valid), 32'd0);
    check("t4_abort_rd_addr", 32'(rd_addr), 32'd0);
    check("t4_abort_busy", 32'(dbg_busy), 32'd0);
    repeat (5) step();
    check("t4_no_done", n_done, d0);
    check("t4_stays_idle", 32'(out_valid), 32'd0);
    run_dump("t4b", 1'b1, -1, -1);

    // 5: asynchronous reset mid-dump at address 40
    fill_random();
    start_dump("t5");
    run_to_addr(40, found);
    check("t5_reach40", 32'(found), 32'd1);
    d0    = n_done;
    rst_n = 1'b0;
    #1;
    check("t5_rst_rd_addr", 32'(rd_addr), 32'd0);
    check("t5_rst_busy", 32'(dbg_busy), 32'd0);
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_data", out_data, 32'd0);
    check("t5_rst_addr", 32'(out_addr), 32'd0);
    check("t5_rst_last", 32'(out_last), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
`ifdef IREG_DUMP_CSUM_EN
    check("t5_rst_csum", csum, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    stall_prev = 1'b0;
    repeat (4) step();
    check("t5_no_done", n_done, d0);
    check("t5_idle_busy", 32'(dbg_busy), 32'd0);

    // 6: checksum pattern (XOR over the dump cancels to zero)
    for (int k = 0; k < NREG; k++) mem[k] = 32'hA5A5_0000 | 32'(k);
    run_dump("t6", 1'b1, -1, -1);
`ifdef IREG_DUMP_CSUM_EN
    check("t6_csum_zero", csum, 32'h0000_0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
